// File: rtl/crtc_row_dma.sv
`default_nettype none
// ============================================================================
// Module   : crtc_row_dma
// Purpose  : CRTC text-row DMA. On each row start it requests the CPU bus and
//            copies ROW_BYTES of VRAM into one bank of a ping-pong row buffer,
//            while the display reads the row fetched previously from the other bank.
//            Define CRTC_DMA_STRETCH_EN to hold busreq WAIT_CYCLES clks after a row.
// Revision : 1.0  initial release
// ============================================================================
module crtc_row_dma #(
  parameter int ADR_W       = 17,
  parameter int ROW_BYTES   = 120,
  parameter int BUF_AW      = 7,
  parameter int WAIT_CYCLES = 1500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              row_start,
  input  logic              dma_en,
  input  logic [ADR_W-1:0]  base_adr,
  output logic              busreq,
  input  logic              busack,
  output logic [ADR_W-1:0]  ram_adr,
  input  logic [7:0]        ram_data,
  input  logic [BUF_AW-1:0] rd_adr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              overrun,
  output logic              blank
);

`ifdef CRTC_DMA_STRETCH_EN
  localparam bit c_stretch = 1'b1;
`else
  localparam bit c_stretch = 1'b0;
`endif
  localparam bit                c_hold_en = c_stretch && (WAIT_CYCLES > 0);
  localparam logic [BUF_AW-1:0] c_last    = BUF_AW'(ROW_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [ADR_W-1:0]   r_src;
  logic [BUF_AW-1:0]  r_dst;
  logic               r_fill_bank;
  logic               r_overrun;
  logic               w_start_fetch;
  logic               w_wr_en;
  logic               w_hold_done;
  logic [7:0]         row_buf [0:(2**(BUF_AW+1))-1];

  generate
    if (c_hold_en) begin : g_hold
      localparam int c_wait_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
      logic [c_wait_w-1:0] r_hold_cnt;

      // Reloaded every cycle outside HOLD, so it holds the full count on entry.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_hold_cnt <= '0;
        end else if (r_state != S_HOLD) begin
          r_hold_cnt <= c_wait_w'(WAIT_CYCLES - 1);
        end else if (r_hold_cnt != '0) begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end
      end
      assign w_hold_done = (r_hold_cnt == '0);
    end else begin : g_no_hold
      assign w_hold_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_start_fetch = 1'b0;
    w_wr_en       = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (row_start && dma_en) begin
          w_state_nx    = S_REQ;
          w_start_fetch = 1'b1;
        end
      end
      S_REQ:  if (busack) w_state_nx = S_ADDR;
      S_ADDR: if (busack) w_state_nx = S_DATA;
      S_DATA: begin
        if (busack) begin
          w_wr_en = dma_en && !frame_start;
          if (r_dst == c_last) w_state_nx = c_hold_en ? S_HOLD : S_IDLE;
          else                 w_state_nx = S_ADDR;
        end
      end
      S_HOLD:  if (w_hold_done) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // Stop command and frame restart both abandon an in-flight row.
    if (r_state != S_IDLE && (!dma_en || frame_start)) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_fill_bank <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_start_fetch) begin
        r_fill_bank <= ~r_fill_bank;
        r_dst       <= '0;
      end
      if (w_wr_en) begin
        r_dst <= r_dst + 1'b1;
        r_src <= r_src + 1'b1;
      end
      // Reload wins over a same-cycle row start, so that row begins at base_adr.
      if (frame_start) begin
        r_src     <= base_adr;
        r_overrun <= 1'b0;
      end else if (row_start && busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) row_buf[{r_fill_bank, r_dst}] <= ram_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= row_buf[{~r_fill_bank, rd_adr}];
  end

  assign busreq  = busy && dma_en;
  assign ram_adr = r_src;
  assign overrun = r_overrun;
  assign blank   = ~dma_en;

endmodule
`default_nettype wire

// File: tb/tb_crtc_row_dma.sv
`default_nettype none
// Bench for crtc_row_dma: cycle vectors on a 4-byte wrap-around instance plus
// directed row sequences on a full 120-byte instance.
module tb_crtc_row_dma;

`ifdef CRTC_DMA_STRETCH_EN
  localparam bit STR = 1'b1;
`else
  localparam bit STR = 1'b0;
`endif
  localparam int ROW_CYC = 1 + 2 * 120 + (STR ? 4 : 0);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Full-size instance
  logic        b_fs = 1'b0, b_rs = 1'b0, b_en = 1'b0, b_ack = 1'b0;
  logic [16:0] b_base = 17'h0F300;
  logic [6:0]  b_rd_adr = '0;
  logic [7:0]  b_ram_data = '0;
  logic        b_busreq, b_busy, b_ov, b_blank;
  logic [16:0] b_adr;
  logic [7:0]  b_rd_data;

  // Small wrap-around instance
  logic        s_fs = 1'b0, s_rs = 1'b0, s_en = 1'b0, s_ack = 1'b0;
  logic [16:0] s_base = 17'h1FFFF;
  logic [1:0]  s_rd_adr = '0;
  logic [7:0]  s_ram_data = '0;
  logic        s_busreq, s_busy, s_ov, s_blank;
  logic [16:0] s_adr;
  logic [7:0]  s_rd_data;

  crtc_row_dma #(.ADR_W(17), .ROW_BYTES(120), .BUF_AW(7), .WAIT_CYCLES(4)) u_big (
    .clk(clk), .reset(reset), .frame_start(b_fs), .row_start(b_rs), .dma_en(b_en),
    .base_adr(b_base), .busreq(b_busreq), .busack(b_ack), .ram_adr(b_adr),
    .ram_data(b_ram_data), .rd_adr(b_rd_adr), .rd_data(b_rd_data), .busy(b_busy),
    .overrun(b_ov), .blank(b_blank)
  );

  crtc_row_dma #(.ADR_W(17), .ROW_BYTES(4), .BUF_AW(2), .WAIT_CYCLES(4)) u_small (
    .clk(clk), .reset(reset), .frame_start(s_fs), .row_start(s_rs), .dma_en(s_en),
    .base_adr(s_base), .busreq(s_busreq), .busack(s_ack), .ram_adr(s_adr),
    .ram_data(s_ram_data), .rd_adr(s_rd_adr), .rd_data(s_rd_data), .busy(s_busy),
    .overrun(s_ov), .blank(s_blank)
  );

  // VRAM model: data = low address byte, returned one clock after the address.
  always @(posedge clk) begin
    b_ram_data <= b_adr[7:0];
    s_ram_data <= s_adr[7:0];
  end

  int b_busy_cycles = 0;
  always @(negedge clk) if (b_busy) b_busy_cycles <= b_busy_cycles + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, fs, rs, en, ack;
    logic        e_req, e_busy, e_ov;
    logic [16:0] e_adr;
  } vec_t;

  // in5 = {rst, frame_start, row_start, dma_en, busack}; ex3 = {busreq, busy, overrun}
  function automatic vec_t mk(input bit [4:0] in5, input bit [2:0] ex3, input logic [16:0] adr);
    vec_t v;
    {v.rst, v.fs, v.rs, v.en, v.ack} = in5;
    {v.e_req, v.e_busy, v.e_ov}      = ex3;
    v.e_adr                          = adr;
    return v;
  endfunction

  task automatic start_row();
    b_rs = 1'b1;
    @(negedge clk);
    b_rs = 1'b0;
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (b_busy && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("idle_timeout", 0, 32'(b_busy), 32'd0);
  endtask

  vec_t       tbl [34];
  logic [7:0] s_exp [4];
  int         c0;

  initial begin
    tbl[0]  = mk(5'b01010, 3'b000, 17'h00000); // reload from base
    tbl[1]  = mk(5'b00110, 3'b000, 17'h1FFFF); // row start
    tbl[2]  = mk(5'b00010, 3'b110, 17'h1FFFF); // REQ waiting for grant
    tbl[3]  = mk(5'b00011, 3'b110, 17'h1FFFF);
    tbl[4]  = mk(5'b00011, 3'b110, 17'h1FFFF); // ADDR
    tbl[5]  = mk(5'b00011, 3'b110, 17'h1FFFF); // DATA byte 0
    tbl[6]  = mk(5'b00011, 3'b110, 17'h00000); // address wrapped
    tbl[7]  = mk(5'b00010, 3'b110, 17'h00000); // DATA stalled by busack
    tbl[8]  = mk(5'b00011, 3'b110, 17'h00000);
    tbl[9]  = mk(5'b00111, 3'b110, 17'h00001); // row start while busy
    tbl[10] = mk(5'b00011, 3'b111, 17'h00001);
    tbl[11] = mk(5'b00011, 3'b111, 17'h00002);
    tbl[12] = mk(5'b00011, 3'b111, 17'h00002); // last byte
    tbl[13] = mk(5'b00011, {STR, STR, 1'b1}, 17'h00003);
    tbl[14] = mk(5'b00011, {STR, STR, 1'b1}, 17'h00003);
    tbl[15] = mk(5'b00011, {STR, STR, 1'b1}, 17'h00003);
    tbl[16] = mk(5'b00011, {STR, STR, 1'b1}, 17'h00003);
    tbl[17] = mk(5'b01010, 3'b001, 17'h00003); // frame start clears overrun
    tbl[18] = mk(5'b00110, 3'b000, 17'h1FFFF);
    tbl[19] = mk(5'b00011, 3'b110, 17'h1FFFF);
    tbl[20] = mk(5'b00011, 3'b110, 17'h1FFFF);
    tbl[21] = mk(5'b00001, 3'b010, 17'h1FFFF); // dma_en drop masks busreq at once
    tbl[22] = mk(5'b00101, 3'b000, 17'h1FFFF); // row start ignored while disabled
    tbl[23] = mk(5'b00011, 3'b000, 17'h1FFFF);
    tbl[24] = mk(5'b00111, 3'b000, 17'h1FFFF);
    tbl[25] = mk(5'b00011, 3'b110, 17'h1FFFF);
    tbl[26] = mk(5'b00011, 3'b110, 17'h1FFFF);
    tbl[27] = mk(5'b01011, 3'b110, 17'h1FFFF); // frame start aborts fetch
    tbl[28] = mk(5'b00011, 3'b000, 17'h1FFFF);
    tbl[29] = mk(5'b00111, 3'b000, 17'h1FFFF);
    tbl[30] = mk(5'b00011, 3'b110, 17'h1FFFF);
    tbl[31] = mk(5'b00011, 3'b110, 17'h1FFFF);
    tbl[32] = mk(5'b10011, 3'b110, 17'h1FFFF); // reset mid-fetch
    tbl[33] = mk(5'b00010, 3'b000, 17'h00000);
    s_exp = '{8'hFF, 8'h00, 8'h01, 8'h02};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_busreq", 0, 32'(s_busreq), 32'd0);
    chk("rst_s_adr", 0, 32'(s_adr), 32'd0);
    chk("rst_b_busy", 0, 32'(b_busy), 32'd0);
    chk("rst_b_ov", 0, 32'(b_ov), 32'd0);
    chk("rst_b_rd_data", 0, 32'(b_rd_data), 32'd0);
    chk("rst_b_blank", 0, 32'(b_blank), 32'd1);

    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      s_fs  = tbl[i].fs;
      s_rs  = tbl[i].rs;
      s_en  = tbl[i].en;
      s_ack = tbl[i].ack;
      #1;
      chk("s_busreq", i, 32'(s_busreq), 32'(tbl[i].e_req));
      chk("s_busy", i, 32'(s_busy), 32'(tbl[i].e_busy));
      chk("s_overrun", i, 32'(s_ov), 32'(tbl[i].e_ov));
      chk("s_ram_adr", i, 32'(s_adr), 32'(tbl[i].e_adr));
      chk("s_blank", i, 32'(s_blank), 32'(!tbl[i].en));
    end
    reset = 1'b0;
    s_ack = 1'b0;

    // Bank 1 still holds the wrapped row fetched at the start of the table.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) chk("s_rd_data", i - 1, 32'(s_rd_data), 32'(s_exp[i-1]));
      if (i < 4) s_rd_adr = 2'(i);
    end

    // Full row from 0xF300 with busack tied high
    b_en = 1'b1;
    @(negedge clk);
    b_fs = 1'b1;
    @(negedge clk);
    b_fs = 1'b0;
    #1;
    chk("b_reload_adr", 0, 32'(b_adr), 32'h0F300);
    chk("b_blank_en", 0, 32'(b_blank), 32'd0);
    b_ack = 1'b1;
    c0 = b_busy_cycles;
    start_row();
    wait_idle();
    chk("row1_cycles", 0, 32'(b_busy_cycles - c0), 32'(ROW_CYC));
    chk("row1_end_adr", 0, 32'(b_adr), 32'h0F378);
    chk("row1_overrun", 0, 32'(b_ov), 32'd0);

    // Second row: swap shows row 1; a row start 50 clks in must only flag overrun
    c0 = b_busy_cycles;
    start_row();
    b_rd_adr = 7'd5;
    @(negedge clk); #1;
    chk("row1_byte5", 0, 32'(b_rd_data), 32'h05);
    b_rd_adr = 7'd0;
    @(negedge clk); #1;
    chk("row1_byte0", 0, 32'(b_rd_data), 32'h00);
    b_rd_adr = 7'd119;
    @(negedge clk); #1;
    chk("row1_byte119", 0, 32'(b_rd_data), 32'h77);
    repeat (46) @(negedge clk);
    #1;
    chk("row2_busy_mid", 0, 32'(b_busy), 32'd1);
    start_row();
    chk("row2_overrun", 0, 32'(b_ov), 32'd1);
    wait_idle();
    chk("row2_cycles", 0, 32'(b_busy_cycles - c0), 32'(ROW_CYC));
    chk("row2_end_adr", 0, 32'(b_adr), 32'h0F3F0);
    chk("row2_overrun_held", 0, 32'(b_ov), 32'd1);
    b_rd_adr = 7'd5;
    @(negedge clk); #1;
    chk("no_swap_byte5", 0, 32'(b_rd_data), 32'h05);

    // Third row start swaps in row 2; frame start then aborts and clears overrun
    start_row();
    @(negedge clk); #1;
    chk("row2_byte5", 0, 32'(b_rd_data), 32'h7D);
    b_fs = 1'b1;
    @(negedge clk);
    b_fs = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(b_busy), 32'd0);
    chk("abort_overrun", 0, 32'(b_ov), 32'd0);
    chk("abort_adr", 0, 32'(b_adr), 32'h0F300);

    // Grant withheld 10 clks: request stays up, address does not move
    b_ack = 1'b0;
    c0 = b_busy_cycles;
    start_row();
    for (int i = 0; i < 10; i++) begin
      chk("nogrant_busreq", i, 32'(b_busreq), 32'd1);
      chk("nogrant_adr", i, 32'(b_adr), 32'h0F300);
      @(negedge clk);
      #1;
    end
    b_ack = 1'b1;
    wait_idle();
    chk("nogrant_cycles", 0, 32'(b_busy_cycles - c0), 32'(ROW_CYC + 10));
    chk("nogrant_end_adr", 0, 32'(b_adr), 32'h0F378);

    b_en = 1'b0;
    #1;
    chk("stop_blank", 0, 32'(b_blank), 32'd1);
    chk("stop_busreq", 0, 32'(b_busreq), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
